// File: rtl/mem_responder_if.sv
// Command/response bundle between a memory bench (master) and the
// mem_responder target (slave). Widths follow the DEPTH/WIDTH parameters.
interface mem_responder_if #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(DEPTH);

  // Command side
  logic             read;
  logic             write;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] data_in;
  logic             clear_req;

  // Response / status side
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             uninit;
  logic             busy;
  logic             cmd_err;
  logic [15:0]      wr_count;
  logic [15:0]      rd_count;

  modport master (
    output read, write, addr, data_in, clear_req,
    input  data_out, rd_valid, uninit, busy, cmd_err, wr_count, rd_count
  );

  modport slave (
    input  read, write, addr, data_in, clear_req,
    output data_out, rd_valid, uninit, busy, cmd_err, wr_count, rd_count
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port memory target: DEPTH x WIDTH storage with a fixed-latency read
// pipeline, a written-location bitmap that flags reads of never-written words,
// a hardware zero-fill sequence, illegal-command flagging and saturating
// access counters.
module mem_responder #(
  parameter  int DEPTH  = 32,
  parameter  int WIDTH  = 8,
  parameter  int RD_LAT = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [15:0]   CNT_MAX   = 16'hFFFF;

  // Storage (no reset: contents survive rst_n)
  logic [WIDTH-1:0] mem [DEPTH];

  // Control state
  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [DEPTH-1:0] written_q, written_d;
  logic [15:0]      wr_count_q, wr_count_d;
  logic [15:0]      rd_count_q, rd_count_d;
  logic             cmd_err_q;

  // Read pipeline: stage 0 is loaded at the command edge, the last stage
  // drives the outputs. Data/uninit only advance alongside a valid token so
  // the output word holds between reads.
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] uni_q;
  logic [WIDTH-1:0]  dat_q [RD_LAT];

  // Command decode
  logic             busy_w;
  logic             cmd_any;
  logic             illegal;
  logic             wr_acc;
  logic             rd_acc;
  logic             clr_start;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  // Classify the command seen at this edge as accepted or illegal.
  always_comb begin
    busy_w    = (state_q == ST_CLEAR);
    cmd_any   = bus.read | bus.write;
    illegal   = (bus.read & bus.write)
              | (busy_w & (cmd_any | bus.clear_req))
              | (bus.clear_req & cmd_any);
    wr_acc    = ~busy_w & bus.write & ~bus.read & ~bus.clear_req;
    rd_acc    = ~busy_w & bus.read & ~bus.write & ~bus.clear_req;
    clr_start = ~busy_w & bus.clear_req & ~cmd_any;
  end

  // Single write port shared between the clear sequence and bus writes;
  // gated by rst_n so nothing is stored while held in reset.
  always_comb begin
    mem_we    = rst_n & (busy_w | wr_acc);
    mem_waddr = busy_w ? ptr_q : bus.addr;
    mem_wdata = busy_w ? '0 : bus.data_in;
  end

  // FSM next state: walk ptr across every location once, then return to IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bitmap and counter next state; counters saturate instead of wrapping.
  always_comb begin
    written_d  = written_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    if (busy_w) begin
      written_d[ptr_q] = 1'b1;
    end else if (wr_acc) begin
      written_d[bus.addr] = 1'b1;
    end
    if (wr_acc && (wr_count_q != CNT_MAX)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
    if (rd_acc && (rd_count_q != CNT_MAX)) begin
      rd_count_d = rd_count_q + 16'd1;
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      written_q  <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      written_q  <= written_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
      cmd_err_q  <= illegal;
    end
  end

  // Memory array write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read pipeline: capture word and written flag at the command edge, then
  // shift toward the output; never-written words are returned as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      uni_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) begin
        uni_q[0] <= ~written_q[bus.addr];
        dat_q[0] <= written_q[bus.addr] ? mem[bus.addr] : '0;
      end
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          uni_q[k] <= uni_q[k-1];
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  // Outputs
  assign bus.data_out = dat_q[RD_LAT-1];
  assign bus.rd_valid = vld_q[RD_LAT-1];
  assign bus.uninit   = uni_q[RD_LAT-1];
  assign bus.busy     = busy_w;
  assign bus.cmd_err  = cmd_err_q;
  assign bus.wr_count = wr_count_q;
  assign bus.rd_count = rd_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH=32, WIDTH=8, RD_LAT=1).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_mem_responder;

  localparam int DEPTH = 32;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_responder_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  mem_responder #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    bus.write   = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    tick();
    bus.write = 1'b0;
    $display("WR addr=%0d data=%02h wr_count=%0d", a, d, bus.wr_count);
  endtask

  task automatic do_read(input logic [4:0] a);
    bus.read = 1'b1;
    bus.addr = a;
    tick();
    bus.read = 1'b0;
    $display("RD addr=%0d valid=%0b data=%02h uninit=%0b", a, bus.rd_valid, bus.data_out, bus.uninit);
  endtask

  initial begin
    int          busy_cycles;
    int          guard;
    logic [15:0] wr_before;
    logic [15:0] rd_before;

    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.addr      = '0;
    bus.data_in   = '0;
    bus.clear_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_data_out", 32'(bus.data_out), 32'h0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("rst_uninit",   32'(bus.uninit),   32'h0);
    check("rst_busy",     32'(bus.busy),     32'h0);
    check("rst_cmd_err",  32'(bus.cmd_err),  32'h0);
    check("rst_wr_count", 32'(bus.wr_count), 32'h0);
    check("rst_rd_count", 32'(bus.rd_count), 32'h0);

    // Read of a never-written word
    do_read(5'd5);
    check("uninit_rd_valid", 32'(bus.rd_valid), 32'h1);
    check("uninit_flag",     32'(bus.uninit),   32'h1);
    check("uninit_data",     32'(bus.data_out), 32'h0);
    check("uninit_rd_count", 32'(bus.rd_count), 32'h1);
    tick();
    check("uninit_pulse_end", 32'(bus.rd_valid), 32'h0);

    // Fresh counters for the fill/readback pass
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      do_write(5'(i), 8'(i));
    end
    check("fill_wr_count", 32'(bus.wr_count), 32'd32);
    bus.read = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.addr = 5'(i);
      tick();
      $display("RD addr=%0d valid=%0b data=%02h uninit=%0b", i, bus.rd_valid, bus.data_out, bus.uninit);
      check("b2b_valid",  32'(bus.rd_valid), 32'h1);
      check("b2b_data",   32'(bus.data_out), 32'(i));
      check("b2b_uninit", 32'(bus.uninit),   32'h0);
    end
    bus.read = 1'b0;
    check("b2b_rd_count", 32'(bus.rd_count), 32'd32);
    check("b2b_wr_count", 32'(bus.wr_count), 32'd32);

    // Write then immediate read of the same address
    do_write(5'd31, 8'hA5);
    do_read(5'd31);
    check("wr_rd_31_data",   32'(bus.data_out), 32'hA5);
    check("wr_rd_31_uninit", 32'(bus.uninit),   32'h0);
    do_write(5'd0, 8'h3C);
    do_read(5'd0);
    check("wr_rd_0_data", 32'(bus.data_out), 32'h3C);
    tick();
    check("hold_valid", 32'(bus.rd_valid), 32'h0);
    check("hold_data",  32'(bus.data_out), 32'h3C);

    // Clear sequence with an illegal write injected mid-way
    wr_before     = bus.wr_count;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    $display("CLR start busy=%0b", bus.busy);
    busy_cycles = 0;
    guard       = 0;
    while (bus.busy && guard < 100) begin
      busy_cycles++;
      guard++;
      if (busy_cycles == 10) begin
        bus.write   = 1'b1;
        bus.addr    = 5'd4;
        bus.data_in = 8'h77;
      end
      tick();
      bus.write = 1'b0;
      if (busy_cycles == 10) begin
        check("clr_wr_cmd_err",  32'(bus.cmd_err),  32'h1);
        check("clr_wr_wr_count", 32'(bus.wr_count), 32'(wr_before));
      end
    end
    $display("CLR done busy_cycles=%0d", busy_cycles);
    check("clr_busy_cycles", 32'(busy_cycles), 32'd32);
    check("clr_wr_count",    32'(bus.wr_count), 32'(wr_before));
    for (int i = 0; i < DEPTH; i++) begin
      do_read(5'(i));
      check("clr_rd_data",   32'(bus.data_out), 32'h0);
      check("clr_rd_uninit", 32'(bus.uninit),   32'h0);
    end

    // Read and write together: illegal, no access
    wr_before   = bus.wr_count;
    rd_before   = bus.rd_count;
    bus.read    = 1'b1;
    bus.write   = 1'b1;
    bus.addr    = 5'd7;
    bus.data_in = 8'h55;
    tick();
    bus.read  = 1'b0;
    bus.write = 1'b0;
    $display("RDWR addr=7 cmd_err=%0b valid=%0b", bus.cmd_err, bus.rd_valid);
    check("rdwr_cmd_err",  32'(bus.cmd_err),  32'h1);
    check("rdwr_rd_valid", 32'(bus.rd_valid), 32'h0);
    check("rdwr_wr_count", 32'(bus.wr_count), 32'(wr_before));
    check("rdwr_rd_count", 32'(bus.rd_count), 32'(rd_before));
    do_read(5'd7);
    check("rdwr_loc7_data",    32'(bus.data_out), 32'h0);
    check("rdwr_cmd_err_done", 32'(bus.cmd_err),  32'h0);

    // Reset in the middle of a clear (ptr=10)
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (10) tick();
    check("abort_busy_before", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #2;
    check("abort_busy_in_rst", 32'(bus.busy), 32'h0);
    tick();
    rst_n = 1'b1;
    do_read(5'd3);
    check("abort_rd_valid", 32'(bus.rd_valid), 32'h1);
    check("abort_uninit",   32'(bus.uninit),   32'h1);
    check("abort_data",     32'(bus.data_out), 32'h0);
    check("abort_busy",     32'(bus.busy),     32'h0);

    // Read counter saturation
    bus.read = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      bus.addr = 5'(i);
      tick();
      if (i == 65000) begin
        check("sat_rd_count_mid", 32'(bus.rd_count), 32'd65002);
      end
    end
    bus.read = 1'b0;
    $display("SAT rd_count=%0h", bus.rd_count);
    check("sat_rd_count", 32'(bus.rd_count), 32'hFFFF);
    check("sat_rd_valid", 32'(bus.rd_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synchronous single-port memory responder; it is the target end of the memory interface that the layered memory bench drives with write and read commands.
- Stores DEPTH words of WIDTH bits and returns read data after a fixed latency with a valid strobe.
- Tracks which locations have been written and flags reads of never-written words.
- Provides a hardware clear sequence, protocol-error flagging and saturating access counters for bench checking.

Parameters:
DEPTH, 32, number of words; power of two, minimum 2
WIDTH, 8, data word width in bits
RD_LAT, 1, read latency in clock cycles from command edge to rd_valid; range 1..4
AW, $clog2(DEPTH), address width; derived, not overridden

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
read  input  1  read command, sampled at the rising edge
write  input  1  write command, sampled at the rising edge
addr  input  AW  command address
data_in  input  WIDTH  write data
clear_req  input  1  start the zero-fill sequence over all locations
data_out  output  WIDTH  read data; valid when rd_valid=1
rd_valid  output  1  one-cycle pulse per accepted read, RD_LAT cycles after the command
uninit  output  1  qualifies rd_valid; the location read has never been written since reset
busy  output  1  clear sequence in progress
cmd_err  output  1  one-cycle pulse on an illegal command
wr_count  output  16  accepted writes, saturating at 16'hFFFF
rd_count  output  16  accepted reads, saturating at 16'hFFFF

Behaviour:
- Reset (rst_n=0, asynchronous):
  - data_out=0, rd_valid=0, uninit=0, busy=0, cmd_err=0, wr_count=0, rd_count=0.
  - Written-bitmap cleared, read pipeline flushed, FSM to IDLE, clear pointer 0.
  - Array contents are not reset.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR when clear_req=1 and no read or write is asserted in the same cycle.
  - CLEAR writes 0 to location ptr and sets written[ptr]; ptr increments by 1 per cycle.
  - CLEAR -> IDLE after the write to ptr=DEPTH-1; ptr wraps to 0.
  - busy=1 throughout CLEAR, i.e. exactly DEPTH cycles.
  - Clear writes do not increment wr_count.
- Write (IDLE, write=1, read=0): mem[addr]<=data_in, written[addr]<=1, wr_count+1.
- Read (IDLE, read=1, write=0):
  - The word at addr is captured at the command edge.
  - After RD_LAT cycles: rd_valid=1, data_out=captured word, uninit=~written[addr] as sampled at the command edge.
  - When uninit=1, data_out=0.
  - rd_count+1.
- Back-to-back reads on consecutive cycles are accepted; the pipeline returns one rd_valid per read, in order.
- data_out holds its last value while rd_valid=0.
- Read of an address written on the previous edge returns the new data.
- A write followed by a read of the same address on the next cycle returns the new data (no bypass is needed).
- Illegal commands: pulse cmd_err for one cycle and perform no access or counter change when any of these is seen at an edge:
  - read=1 and write=1 together;
  - read, write or clear_req while busy=1;
  - clear_req together with read or write.
- clear_req while already in CLEAR is ignored; cmd_err still pulses.
- Reads issued before a clear still complete through the pipeline during CLEAR.
- Reset during CLEAR aborts the sequence.
  - Locations already zeroed keep their value.
  - The bitmap is cleared, so all locations read back with uninit=1.
- Address wrap: addr is exactly AW bits, so every value is a legal location.
- Counters stop at 16'hFFFF and never wrap.

Test Plan:
- Reset, then read addr 5 -> after RD_LAT: rd_valid=1, uninit=1, data_out=0, rd_count=1.
- Write addr 0..31 with data=addr, then read addr 0..31 back to back -> 32 rd_valid pulses in order, data_out=0..31, uninit=0, wr_count=32, rd_count=32.
- Write 8'hA5 to addr 31, read addr 31 on the next cycle -> data_out=8'hA5, uninit=0. Then write 8'h3C to addr 0, read addr 0 -> data_out=8'h3C.
- Pulse clear_req -> busy=1 for exactly 32 cycles. A write issued mid-clear gives cmd_err=1 and wr_count unchanged. After clear, reading all 32 addresses gives data_out=0, uninit=0.
- Assert read=1 and write=1 at addr 7 with data 8'h55 -> cmd_err pulse, no rd_valid, location 7 unchanged, counters unchanged.
- Start a clear, drop rst_n at ptr=10, release, read addr 3 -> rd_valid=1, uninit=1, busy=0. Then 70000 reads -> rd_count=16'hFFFF.
